// File: rtl/aes_apb_pkg.sv
// aes_apb_pkg: register map, sequencer state encoding and block<->word packing for aes_apb_seq
package aes_apb_pkg;
  localparam logic [15:0] A_START = 16'h0000;
  localparam logic [15:0] A_SIZE  = 16'h0004;
  localparam logic [15:0] A_KEY   = 16'h2000;
  localparam logic [15:0] A_PT    = 16'h4000;
  localparam logic [15:0] A_CT    = 16'h6000;
  localparam logic [15:0] A_IEN   = 16'hA000;
  localparam logic [15:0] A_PEND  = 16'hA004;
  localparam logic [15:0] A_IMSK  = 16'hA008;
  typedef enum logic [3:0] {
    S_IDLE, S_W_PT, S_W_KEY, S_W_IEN, S_W_SIZE, S_W_START,
    S_WAIT_INT, S_R_PEND, S_W_CLR, S_R_CT, S_OUT
  } state_t;
  typedef logic [3:0][31:0] blk_words_t;
  // Block byte j sits at [127-8j -: 8]; word k = {byte4k+3, byte4k+2, byte4k+1, byte4k}.
  function automatic blk_words_t pack_blk(input logic [127:0] b);
    blk_words_t w;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++)
        w[k][8*i +: 8] = b[127-8*(4*k+i) -: 8];
    return w;
  endfunction
  function automatic logic [127:0] unpack_blk(input blk_words_t w);
    logic [127:0] b;
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++)
        b[127-8*(4*k+i) -: 8] = w[k][8*i +: 8];
    return b;
  endfunction
endpackage

// File: rtl/apb_xfer.sv
// apb_xfer: single APB transfer engine (SETUP then ACCESS, no PREADY)
//   req_i/write_i/addr_i/wdata_i : transfer request, held by the sequencer until done_o
//   done_o/rdata_o               : pulse in the ACCESS cycle; rdata_o valid at the edge ending it
//   psel_o..pwdata_o             : APB master outputs, all zero while no request is pending
module apb_xfer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        write_i,
  input  logic [15:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] prdata_i,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [15:0] paddr_o,
  output logic [31:0] pwdata_o
);
  logic phase_q, phase_d;
  // A request still held after done starts the next SETUP immediately, keeping psel high.
  assign phase_d   = req_i & ~phase_q;
  assign done_o    = req_i & phase_q;
  assign rdata_o   = prdata_i;
  assign psel_o    = req_i;
  assign penable_o = req_i & phase_q;
  assign pwrite_o  = req_i & write_i;
  assign paddr_o   = req_i ? addr_i : '0;
  assign pwdata_o  = (req_i & write_i) ? wdata_i : '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) phase_q <= 1'b0;
    else       phase_q <= phase_d;
  end
endmodule

// File: rtl/aes_apb_seq.sv
// aes_apb_seq: APB master sequencer driving one AES coprocessor operation per accepted block
//   iClk/iRst                   : clock, synchronous active-high reset
//   iInValid/oInReady           : input stream (iText, iKey, iKeyLoad), ready only in IDLE
//   oPsel..oPwdata, iPrdata     : APB master port to the coprocessor
//   iInt                        : coprocessor interrupt level
//   oOutValid/iOutReady/oCipher : ciphertext output stream
//   oTimeout/oBusy              : sticky interrupt-timeout flag, not-idle indicator
module aes_apb_seq
  import aes_apb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096,
  parameter int BYTE_SIZE   = 16
) (
  input  logic         iClk,
  input  logic         iRst,
  input  logic         iInValid,
  output logic         oInReady,
  input  logic         iKeyLoad,
  input  logic [127:0] iKey,
  input  logic [127:0] iText,
  output logic         oPsel,
  output logic         oPenable,
  output logic         oPwrite,
  output logic [15:0]  oPaddr,
  output logic [31:0]  oPwdata,
  input  logic [31:0]  iPrdata,
  input  logic         iInt,
  output logic         oOutValid,
  input  logic         iOutReady,
  output logic [127:0] oCipher,
  output logic         oTimeout,
  output logic         oBusy
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic         timeout_q, timeout_d;
  blk_words_t   ct_q, ct_d;
  logic [127:0] text_q, key_q;
  logic         load_key_q, key_loaded_q;
  logic         accept, req, wr, done;
  logic [15:0]  addr, offs;
  logic [31:0]  wdata, rdata;
  blk_words_t   pt_w, key_w;
  assign accept    = (state_q == S_IDLE) & iInValid;
  assign pt_w      = pack_blk(text_q);
  assign key_w     = pack_blk(key_q);
  assign offs      = {12'd0, cnt_q, 2'b00};
  assign oInReady  = state_q == S_IDLE;
  assign oBusy     = state_q != S_IDLE;
  assign oOutValid = state_q == S_OUT;
  assign oCipher   = unpack_blk(ct_q);
  assign oTimeout  = timeout_q;
  apb_xfer u_xfer (
    .clk_i    (iClk),
    .rst_i    (iRst),
    .req_i    (req),
    .write_i  (wr),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .prdata_i (iPrdata),
    .done_o   (done),
    .rdata_o  (rdata),
    .psel_o   (oPsel),
    .penable_o(oPenable),
    .pwrite_o (oPwrite),
    .paddr_o  (oPaddr),
    .pwdata_o (oPwdata)
  );
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    timeout_d = timeout_q;
    ct_d      = ct_q;
    req       = 1'b0;
    wr        = 1'b0;
    addr      = '0;
    wdata     = '0;
    case (state_q)
      S_IDLE: begin
        if (iInValid) begin
          state_d   = S_W_PT;
          cnt_d     = '0;
          timeout_d = 1'b0;
        end
      end
      S_W_PT: begin
        req   = 1'b1;
        wr    = 1'b1;
        addr  = A_PT | offs;
        wdata = pt_w[cnt_q];
        if (done) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = load_key_q ? S_W_KEY : S_W_IEN;
        end
      end
      S_W_KEY: begin
        req   = 1'b1;
        wr    = 1'b1;
        addr  = A_KEY | offs;
        wdata = key_w[cnt_q];
        if (done) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_W_IEN;
        end
      end
      S_W_IEN: begin
        req   = 1'b1;
        wr    = 1'b1;
        addr  = cnt_q[0] ? A_IMSK : A_IEN;
        wdata = 32'd1;
        if (done) begin
          cnt_d   = cnt_q[0] ? 2'd0 : 2'd1;
          state_d = cnt_q[0] ? S_W_SIZE : S_W_IEN;
        end
      end
      S_W_SIZE: begin
        req   = 1'b1;
        wr    = 1'b1;
        addr  = A_SIZE;
        wdata = 32'(BYTE_SIZE);
        if (done) state_d = S_W_START;
      end
      S_W_START: begin
        req   = 1'b1;
        wr    = 1'b1;
        addr  = A_START;
        wdata = 32'd1;
        if (done) begin
          state_d = S_WAIT_INT;
          tmo_d   = '0;
        end
      end
      S_WAIT_INT: begin
        // The counter keeps its value across a spurious-interrupt round trip.
        if (iInt) state_d = S_R_PEND;
        else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else tmo_d = tmo_q + 1'b1;
      end
      S_R_PEND: begin
        req  = 1'b1;
        addr = A_PEND;
        if (done) state_d = rdata[0] ? S_W_CLR : S_WAIT_INT;
      end
      S_W_CLR: begin
        req   = 1'b1;
        wr    = 1'b1;
        addr  = A_PEND;
        wdata = 32'd1;
        if (done) begin
          state_d = S_R_CT;
          cnt_d   = '0;
        end
      end
      S_R_CT: begin
        req  = 1'b1;
        addr = A_CT | offs;
        if (done) begin
          ct_d[cnt_q] = rdata;
          cnt_d       = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (iOutReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tmo_q        <= '0;
      timeout_q    <= 1'b0;
      ct_q         <= '0;
      text_q       <= '0;
      key_q        <= '0;
      load_key_q   <= 1'b0;
      key_loaded_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
      ct_q      <= ct_d;
      if (accept) begin
        text_q     <= iText;
        key_q      <= iKey;
        // With no key loaded since reset the key must be written regardless of iKeyLoad.
        load_key_q <= iKeyLoad | ~key_loaded_q;
      end
      if (state_q == S_W_KEY) key_loaded_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_aes_apb_seq.sv
// tb_aes_apb_seq: scoreboard bench for aes_apb_seq with a directed coprocessor slave model
module tb_aes_apb_seq;
  typedef struct packed {logic wr; logic [15:0] a; logic [31:0] d;} apb_t;
  localparam logic [127:0] TXT1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] KEY1 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] TXT2 = 128'h3243F6A8885A308D313198A2E0370734;
  localparam logic [127:0] KEY2 = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] PT1  = 128'h33221100_77665544_BBAA9988_FFEEDDCC;
  localparam logic [127:0] K1W  = 128'h03020100_07060504_0B0A0908_0F0E0D0C;
  localparam logic [127:0] PT2  = 128'hA8F64332_8D305A88_A2983131_340737E0;
  localparam logic [127:0] K2W  = 128'h16157E2B_A6D2AE28_8815F7AB_3C4FCF09;
  localparam logic [127:0] CT   = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
  logic iClk, iRst, iInValid, oInReady, iKeyLoad, oPsel, oPenable, oPwrite;
  logic iInt, oOutValid, iOutReady, oTimeout, oBusy, pend;
  logic [127:0] iKey, iText, oCipher;
  logic [15:0] oPaddr;
  logic [31:0] oPwdata, iPrdata;
  int compared = 0, mismatched = 0;
  apb_t exp_q[$];
  logic [127:0] out_q[$];
  aes_apb_seq #(.TIMEOUT_CYC(64), .BYTE_SIZE(16)) dut (
    .iClk(iClk), .iRst(iRst), .iInValid(iInValid), .oInReady(oInReady),
    .iKeyLoad(iKeyLoad), .iKey(iKey), .iText(iText),
    .oPsel(oPsel), .oPenable(oPenable), .oPwrite(oPwrite), .oPaddr(oPaddr),
    .oPwdata(oPwdata), .iPrdata(iPrdata), .iInt(iInt),
    .oOutValid(oOutValid), .iOutReady(iOutReady), .oCipher(oCipher),
    .oTimeout(oTimeout), .oBusy(oBusy)
  );
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;
  always_comb begin
    case (oPaddr)
      16'hA004: iPrdata = {31'd0, pend};
      16'h6000: iPrdata = 32'hD8E0C469;
      16'h6004: iPrdata = 32'h30047B6A;
      16'h6008: iPrdata = 32'h80B7CDD8;
      16'h600C: iPrdata = 32'h5AC5B470;
      default:  iPrdata = 32'h0;
    endcase
  end
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic push_w(input logic [15:0] a, input logic [31:0] d);
    exp_q.push_back('{1'b1, a, d});
  endtask
  task automatic push_r(input logic [15:0] a);
    exp_q.push_back('{1'b0, a, 32'h0});
  endtask
  task automatic push_op(input logic [127:0] ptw, input logic [127:0] kw, input bit with_key);
    for (int k = 0; k < 4; k++) push_w(16'h4000 + 16'(4*k), ptw[127-32*k -: 32]);
    if (with_key) for (int k = 0; k < 4; k++) push_w(16'h2000 + 16'(4*k), kw[127-32*k -: 32]);
    push_w(16'hA000, 32'd1);
    push_w(16'hA008, 32'd1);
    push_w(16'h0004, 32'd16);
    push_w(16'h0000, 32'd1);
  endtask
  task automatic push_tail();
    push_r(16'hA004);
    push_w(16'hA004, 32'd1);
    for (int k = 0; k < 4; k++) push_r(16'h6000 + 16'(4*k));
    out_q.push_back(CT);
  endtask
  task automatic start_op(input logic [127:0] t, input logic [127:0] k, input logic ld, input int lat);
    int n = 0;
    while (!oInReady && n < 500) begin @(negedge iClk); n++; end
    iText = t; iKey = k; iKeyLoad = ld; iInValid = 1'b1;
    @(negedge iClk);
    iInValid = 1'b0;
    check("timeout_clr", 128'(oTimeout), 128'(0));
    n = 0;
    while (oPsel && n < 100) begin n++; @(negedge iClk); end
    check("latency", 128'(n), 128'(lat));
    check("wait_int_bus", 128'({oBusy, oPsel}), 128'(2'b10));
  endtask
  task automatic service_int();
    int n = 0;
    iInt = 1'b1; pend = 1'b1;
    while (!(oPsel && oPenable && oPwrite && oPaddr == 16'hA004) && n < 50) begin @(negedge iClk); n++; end
    check("clear_write_seen", 128'(n < 50), 128'(1));
    iInt = 1'b0; pend = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (!oInReady && n < 200) begin @(negedge iClk); n++; end
    check("back_to_idle", 128'({oInReady, oBusy}), 128'(2'b10));
  endtask
  initial begin
    int n;
    logic [127:0] c;
    bit stable;
    iRst = 1'b1; iInValid = 1'b0; iKeyLoad = 1'b0; iKey = '0; iText = '0;
    iInt = 1'b0; pend = 1'b0; iOutReady = 1'b1;
    fork
      begin #500000; $display("FAIL watchdog: simulation did not complete"); $fatal(1, "watchdog"); end
      forever begin : mon
        apb_t e;
        @(negedge iClk);
        if (!iRst && oPsel && oPenable) begin
          if (exp_q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL apb_unexpected: got %b %h %h expected none", oPwrite, oPaddr, oPwdata);
          end else begin
            e = exp_q.pop_front();
            check("apb_xfer", 128'({oPwrite, oPaddr, e.wr ? oPwdata : 32'h0}), 128'(e));
          end
        end
        if (!iRst && oOutValid && iOutReady) begin
          if (out_q.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL out_unexpected: got %h expected none", oCipher);
          end else check("cipher", oCipher, out_q.pop_front());
        end
      end
    join_none
    repeat (3) @(negedge iClk);
    iRst = 1'b0;
    check("rst_apb", 128'({oPsel, oPenable, oPwrite, oPaddr, oPwdata}), 128'(0));
    check("rst_flags", 128'({oInReady, oBusy, oOutValid, oTimeout}), 128'(4'b1000));
    check("rst_cipher", oCipher, 128'(0));
    // key load + encrypt
    push_op(PT1, K1W, 1); push_tail();
    start_op(TXT1, KEY1, 1'b1, 24); service_int(); wait_idle();
    // key reuse with a spurious interrupt first
    push_op(PT2, '0, 0); push_r(16'hA004); push_tail();
    start_op(TXT2, KEY2, 1'b0, 16);
    iInt = 1'b1; pend = 1'b0;
    @(negedge iClk); iInt = 1'b0;
    repeat (2) @(negedge iClk);
    check("spurious_back", 128'({oBusy, oPsel}), 128'(2'b10));
    service_int(); wait_idle();
    // output backpressure
    iOutReady = 1'b0;
    push_op(PT1, '0, 0); push_tail();
    start_op(TXT1, KEY1, 1'b0, 16); service_int();
    n = 0;
    while (!oOutValid && n < 50) begin @(negedge iClk); n++; end
    check("bp_valid", 128'(oOutValid), 128'(1));
    c = oCipher; stable = 1'b1;
    repeat (20) begin @(negedge iClk); if (oCipher !== c || !oOutValid || oInReady) stable = 1'b0; end
    check("bp_stable", 128'(stable), 128'(1));
    check("bp_cipher", c, CT);
    @(posedge iClk); #1 iOutReady = 1'b1;
    repeat (2) @(negedge iClk);
    check("bp_release", 128'({oInReady, oBusy, oOutValid}), 128'(3'b100));
    // timeout
    push_op(PT2, '0, 0);
    start_op(TXT2, KEY2, 1'b0, 16);
    n = 0;
    while (oBusy && n < 200) begin n++; @(negedge iClk); end
    check("timeout_cycles", 128'(n), 128'(64));
    check("timeout_flags", 128'({oTimeout, oInReady, oOutValid}), 128'(3'b110));
    push_op(PT1, '0, 0); push_tail();
    start_op(TXT1, KEY1, 1'b0, 16); service_int(); wait_idle();
    // reset during ciphertext read ACCESS
    push_op(PT2, '0, 0); push_tail();
    start_op(TXT2, KEY1, 1'b0, 16); service_int();
    n = 0;
    while (!(oPsel && oPenable && oPaddr == 16'h6004) && n < 50) begin @(negedge iClk); n++; end
    check("rct_access_seen", 128'(n < 50), 128'(1));
    iRst = 1'b1;
    @(negedge iClk);
    check("midrst_apb", 128'({oPsel, oPenable, oPwrite, oPaddr, oPwdata}), 128'(0));
    check("midrst_flags", 128'({oInReady, oBusy, oOutValid}), 128'(3'b100));
    iRst = 1'b0;
    exp_q.delete(); out_q.delete();
    push_op(PT2, K2W, 1); push_tail();
    start_op(TXT2, KEY2, 1'b0, 24); service_int(); wait_idle();
    repeat (4) @(negedge iClk);
    check("apb_q_drained", 128'(exp_q.size()), 128'(0));
    check("out_q_drained", 128'(out_q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
